// File: rtl/debouncer_entrada_pkg.sv
// debouncer_entrada shared definitions.
// State encodings, default settle length, counter sizing.
`timescale 1ns/1ps
package debouncer_entrada_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETTLING = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  localparam int DEBOUNCE_CYCLES_DEF = 4;

  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchroniser for asynchronous switch levels.
// Clears to zero on asynchronous active-low reset.
`timescale 1ns/1ps
module sincronizador #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/debouncer_entrada.sv
// Switch front-end: synchronise, debounce, hold code with Ready
// until the downstream stage acknowledges it.
`timescale 1ns/1ps
module debouncer_entrada
  import debouncer_entrada_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Switches,
  input  logic             Ack,
  output logic [WIDTH-1:0] Data,
  output logic             Ready
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] r_cand;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_state;

  sincronizador #(
    .WIDTH (WIDTH)
  ) u_sync (
    .i_clk   (Clock),
    .i_rst_n (Reset_n),
    .i_d     (Switches),
    .o_q     (w_sync)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      Data    <= '0;
      Ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sync != Data) begin
            r_cand  <= w_sync;
            r_cnt   <= '0;
            r_state <= ST_SETTLING;
          end
        end
        ST_SETTLING: begin
          if (w_sync == Data) begin
            r_state <= ST_IDLE;
          end else if (w_sync != r_cand) begin
            r_cand <= w_sync;
            r_cnt  <= '0;
          end else if (r_cnt == LAST) begin
            Data    <= r_cand;
            Ready   <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // Switches are ignored here; only Ack releases the hold.
        ST_HOLD: begin
          if (Ack) begin
            Ready   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          Ready   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debouncer_entrada.sv
// Scoreboard bench for debouncer_entrada.
// Directed switch patterns; monitor checks each Ready rise.
`timescale 1ns/1ps
module tb_debouncer_entrada;

  localparam int DC = 4;

  typedef struct {
    logic [3:0] d;
    int         at;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Ack = 1'b0;
  logic [3:0] Switches = 4'hF;
  logic [3:0] Data;
  logic       Ready;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  debouncer_entrada #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Switches (Switches),
    .Ack      (Ack),
    .Data     (Data),
    .Ready    (Ready)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  logic prev_r = 1'b0;
  exp_t e;

  always @(negedge Clock) begin
    if (Ready && !prev_r) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("commit_data", 32'(Data), 32'(e.d));
        chk("commit_edge", cyc, e.at);
      end
    end
    prev_r = Ready;
  end

  task automatic drive(input logic [3:0] v, input bit push);
    @(negedge Clock);
    Switches = v;
    if (push) sb.push_back('{v, cyc + 1 + 2 + DC});
  endtask

  task automatic wait_ready(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clock);
      if (Ready) seen = 1'b1;
    end
    if (!seen) chk(nm, 0, 1);
  endtask

  task automatic do_ack();
    @(negedge Clock);
    Ack = 1'b1;
    @(negedge Clock);
    Ack = 1'b0;
    chk("ack_clears_ready", 32'(Ready), 0);
  endtask

  task automatic commit(input logic [3:0] v);
    drive(v, 1'b1);
    wait_ready("commit_timeout");
    do_ack();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) begin
      @(negedge Clock);
      chk("rst_data", 32'(Data), 0);
      chk("rst_ready", 32'(Ready), 0);
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    sb.push_back('{4'hF, cyc + 1 + 2 + DC});
    wait_ready("rst_release_timeout");
    do_ack();

    commit(4'h0);
    commit(4'h5);
    commit(4'h0);

    drive(4'h5, 1'b0);
    drive(4'h0, 1'b0);
    drive(4'h5, 1'b1);
    wait_ready("bounce_timeout");
    do_ack();
    commit(4'h0);

    drive(4'h3, 1'b0);
    drive(4'h3, 1'b0);
    drive(4'h0, 1'b0);
    repeat (12) @(negedge Clock);
    chk("glitch_data", 32'(Data), 0);
    chk("glitch_ready", 32'(Ready), 0);

    drive(4'h5, 1'b1);
    wait_ready("hold_timeout");
    drive(4'hA, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge Clock);
      chk("hold_data", 32'(Data), 5);
      chk("hold_ready", 32'(Ready), 1);
    end
    @(negedge Clock);
    Ack = 1'b1;
    sb.push_back('{4'hA, cyc + 1 + 1 + DC});
    @(negedge Clock);
    Ack = 1'b0;
    chk("hold_ack_ready", 32'(Ready), 0);
    chk("hold_ack_data", 32'(Data), 5);
    wait_ready("hold_change_timeout");
    do_ack();

    drive(4'h5, 1'b0);
    repeat (5) @(negedge Clock);
    chk("settle_no_ready", 32'(Ready), 0);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_data", 32'(Data), 0);
    chk("async_rst_ready", 32'(Ready), 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    sb.push_back('{4'h5, cyc + 1 + 2 + DC});
    wait_ready("rst_mid_timeout");
    do_ack();

    for (int c = 0; c < 16; c++) begin
      commit(4'(c));
    end

    repeat (10) @(negedge Clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
